// File: rtl/keyscan_pkg.sv
// Shared constants, types and helpers for the wb_keyscan keypad controller.
// Optional macro KEYSCAN_RELEASE_EN is consumed by wb_keyscan.
package keyscan_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int KEY_W    = 4;
  localparam int EV_W     = KEY_W + 1;
  localparam int CNT_W    = 4;

  localparam logic [3:0] REG_STATUS = 4'h0;
  localparam logic [3:0] REG_DATA   = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;

  localparam int VALID_BIT   = 8;
  localparam int RELEASE_BIT = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    PROC
  } scan_state_e;

  function automatic logic [KEY_W-1:0] key_code(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [KEY_W-1:0] r4;
    logic [KEY_W-1:0] c4;
    r4 = {2'b00, row};
    c4 = {2'b00, col};
    return r4 * 4'd3 + c4;
  endfunction

endpackage

// File: rtl/keyscan_fifo.sv
// Synchronous event FIFO; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module keyscan_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_keyscan.sv
// Wishbone 4x3 keypad scanner with debounce and event FIFO.
// Define KEYSCAN_RELEASE_EN to also queue key-release events.
module wb_keyscan
  import keyscan_pkg::*;
#(
  parameter int clk_freq       = 100000000,
  parameter int scan_hz        = 1000,
  parameter int debounce_scans = 4,
  parameter int fifo_depth     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic [2:0]  col,
  output logic [3:0]  fil,
  output logic        intr
);

  localparam int DWELL_RAW = clk_freq / scan_hz;
  localparam int DWELL = (DWELL_RAW < 4) ? 4 : DWELL_RAW;
  localparam int DW_W  = $clog2(DWELL);
  localparam int FC_W  = $clog2(fifo_depth) + 1;

  logic        ack_q, ack_d;
  logic        we_q, we_d;
  logic [1:0]  adr_q, adr_d;
  logic [1:0]  wdat_q, wdat_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        ovf_q, ovf_d;
  logic        intr_q, intr_d;
  logic [2:0]  sync1_q, sync1_d;
  logic [2:0]  sync2_q, sync2_d;

  scan_state_e state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  col_q, col_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [2:0]  raw_q, raw_d;
  logic [NUM_KEYS-1:0] stable_q, stable_d;
  logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic            scan_en;
  logic [KEY_W-1:0] key;
  logic            hit;
  logic            ev_push;
  logic            ev_rel;
  logic [EV_W-1:0] ev_din;

  logic            f_pop;
  logic [EV_W-1:0] f_dout;
  logic            f_full;
  logic            f_empty;
  logic [FC_W-1:0] f_count;
  logic [4:0]      cnt5;
  logic [3:0]      fill4;

  logic        req;
  logic        wr;
  logic        rd;
  logic        is_sta;
  logic        is_dat;
  logic        is_ctl;
  logic [31:0] rdata;
  logic        unused_ok;

  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4],
                       wb_adr_i[1:0], wb_dat_i[31:2]};

  assign scan_en = ctrl_q[0];
  assign key     = key_code(row_q, col_q);
  assign hit     = raw_q[col_q];
  assign ev_din  = {ev_rel, key};

  // Row drive drops as soon as scanning is disabled.
  always_comb begin
    fil = 4'b1111;
    if (state_q != IDLE && scan_en) begin
      fil[row_q] = 1'b0;
    end
  end

  always_comb begin
    sync1_d  = col;
    sync2_d  = sync1_q;
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    dwell_d  = dwell_q;
    raw_d    = raw_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    ev_push  = 1'b0;
    ev_rel   = 1'b0;
    if (!scan_en) begin
      state_d  = IDLE;
      stable_d = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = DRIVE;
          row_d   = '0;
          dwell_d = '0;
        end
        DRIVE: begin
          if (dwell_q == DW_W'(DWELL - 2)) begin
            state_d = SAMPLE;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        SAMPLE: begin
          raw_d   = ~sync2_q;
          col_d   = '0;
          state_d = PROC;
        end
        PROC: begin
          if (hit != stable_q[key]) begin
            if (cnt_q[key] == CNT_W'(debounce_scans - 1)) begin
              stable_d[key] = hit;
              cnt_d[key]    = '0;
`ifdef KEYSCAN_RELEASE_EN
              ev_push = 1'b1;
              ev_rel  = ~hit;
`else
              ev_push = hit;
`endif
            end else begin
              cnt_d[key] = cnt_q[key] + 1'b1;
            end
          end else begin
            cnt_d[key] = '0;
          end
          if (col_q == 2'd2) begin
            row_d   = row_q + 2'd1;
            dwell_d = '0;
            state_d = DRIVE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  keyscan_fifo #(
    .WIDTH (EV_W),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ev_push),
    .pop   (f_pop),
    .din   (ev_din),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign cnt5  = 5'(f_count);
  assign fill4 = cnt5[4] ? 4'hF : cnt5[3:0];

  // Request fields are latched so side effects need not track stb.
  assign req    = wb_stb_i & wb_cyc_i;
  assign ack_d  = req & ~ack_q;
  assign we_d   = ack_d ? wb_we_i : we_q;
  assign adr_d  = ack_d ? wb_adr_i[3:2] : adr_q;
  assign wdat_d = ack_d ? wb_dat_i[1:0] : wdat_q;

  assign wr     = ack_q & we_q;
  assign rd     = ack_q & ~we_q;
  assign is_sta = (adr_q == REG_STATUS[3:2]);
  assign is_dat = (adr_q == REG_DATA[3:2]);
  assign is_ctl = (adr_q == REG_CTRL[3:2]);
  assign f_pop  = rd & is_dat & ~f_empty;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_sta: rdata = {24'b0, fill4, 2'b00, ovf_q, ~f_empty};
      is_dat: begin
        if (!f_empty) begin
          rdata[VALID_BIT]   = 1'b1;
          rdata[RELEASE_BIT] = f_dout[KEY_W];
          rdata[KEY_W-1:0]   = f_dout[KEY_W-1:0];
        end
      end
      is_ctl: rdata = {30'b0, ctrl_q};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    ovf_d  = ovf_q;
    if (wr & is_ctl) begin
      ctrl_d = wdat_q;
    end
    if (wr & is_sta & wdat_q[1]) begin
      ovf_d = 1'b0;
    end
    if (ev_push & f_full & ~f_pop) begin
      ovf_d = 1'b1;
    end
    intr_d = ctrl_q[1] & ~f_empty;
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = ack_q ? rdata : '0;
  assign intr     = intr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
      ctrl_q   <= '0;
      ovf_q    <= 1'b0;
      intr_q   <= 1'b0;
      sync1_q  <= 3'b111;
      sync2_q  <= 3'b111;
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      dwell_q  <= '0;
      raw_q    <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      ack_q    <= ack_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      ctrl_q   <= ctrl_d;
      ovf_q    <= ovf_d;
      intr_q   <= intr_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      dwell_q  <= dwell_d;
      raw_q    <= raw_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_keyscan.sv
// Directed bench for wb_keyscan with a keypad model and
// an event-queue scoreboard.
module tb_wb_keyscan;

  localparam int CLK_FREQ = 1000;
  localparam int SCAN_HZ  = 100;
  localparam int DEB      = 2;
  localparam int DEPTH    = 8;
  localparam int SETTLE   = 250;
`ifdef KEYSCAN_RELEASE_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;
  logic [2:0]  col;
  logic [3:0]  fil;
  logic        intr;

  logic [11:0] pressed;
  int          n_cmp;
  int          n_err;
  int          mon_prints;
  int          exp_q[$];
  bit          ovf_m;
  logic [1:0]  ctrl_m;
  logic        req_e;

  wb_keyscan #(
    .clk_freq       (CLK_FREQ),
    .scan_hz        (SCAN_HZ),
    .debounce_scans (DEB),
    .fifo_depth     (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_ack_o (wb_ack_o),
    .col      (col),
    .fil      (fil),
    .intr     (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) req_e <= wb_stb_i & wb_cyc_i;

  // Passive keypad: a pressed key shorts its column to a low row.
  always_comb begin
    col = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!fil[r] && pressed[r*3+c]) col[c] = 1'b0;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, got, exp);
    end
  endtask

  task automatic mchk(string nm, logic [31:0] got,
                      logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (mon_prints < 10) begin
        $display("FAIL %s @%0t: got 0x%0h expected 0x%0h",
                 nm, $time, got, exp);
      end
      mon_prints++;
    end
  endtask

  function automatic int rowof(logic [3:0] f);
    case (f)
      4'hE:    return 0;
      4'hD:    return 1;
      4'hB:    return 2;
      4'h7:    return 3;
      default: return -1;
    endcase
  endfunction

  task automatic monitor();
    logic [3:0] pf;
    logic       pa;
    logic       ip;
    logic       legal;
    pf = 4'hF;
    pa = 1'b0;
    ip = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pf = 4'hF;
        pa = 1'b0;
        ip = 1'b0;
      end else begin
        legal = (fil inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7});
        mchk("fil_legal", 32'(legal), 32'd1);
        if (!ctrl_m[0]) mchk("fil_idle", 32'(fil), 32'hF);
        if (pf != 4'hF && fil != 4'hF && fil != pf) begin
          mchk("row_order", 32'(rowof(fil)),
               32'((rowof(pf) + 1) % 4));
        end
        mchk("ack_proto", 32'(wb_ack_o), 32'(req_e & ~pa));
        if (!ctrl_m[1] && !ip) mchk("intr_off", 32'(intr), 0);
        pf = fil;
        pa = wb_ack_o;
        ip = ctrl_m[1];
      end
    end
  endtask

  task automatic model_ev(int v);
    if (exp_q.size() < DEPTH) exp_q.push_back(v);
    else ovf_m = 1'b1;
  endtask

  task automatic settle();
    repeat (SETTLE) @(posedge clk);
  endtask

  task automatic press(int k);
    pressed[k] = 1'b1;
    settle();
    model_ev(32'h100 | k);
  endtask

  task automatic release_k(int k);
    pressed[k] = 1'b0;
    settle();
    if (REL) model_ev(32'h110 | k);
  endtask

  task automatic wb(bit w, logic [3:0] off, logic [31:0] d,
                    output logic [31:0] r);
    int lat;
    lat = -1;
    r = '0;
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = w;
    wb_adr_i = {28'b0, off};
    wb_dat_i = d;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o) begin
        lat = i;
        r = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    chk("ack_latency", 32'(lat), 0);
    @(posedge clk);
    #1;
    if (w && off == 4'h8) ctrl_m = d[1:0];
    if (w && off == 4'h0 && d[1]) ovf_m = 1'b0;
  endtask

  task automatic rd_status(output logic [31:0] r);
    int n;
    logic [31:0] e;
    n = exp_q.size();
    e = 32'(((n > 15) ? 15 : n) << 4) | 32'(ovf_m << 1)
      | 32'(n != 0);
    wb(1'b0, 4'h0, 0, r);
    chk("status_model", r, e);
  endtask

  task automatic rd_data(output logic [31:0] r);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 0;
    wb(1'b0, 4'h4, 0, r);
    chk("data_model", r, e);
  endtask

  task automatic drain();
    logic [31:0] r;
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      rd_data(r);
      guard++;
    end
  endtask

  task automatic wait_fil(logic [3:0] f);
    int n;
    n = 0;
    while (fil !== f && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_fil", 32'(fil), 32'(f));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int acks;
    n_cmp = 0;
    n_err = 0;
    mon_prints = 0;
    ovf_m = 1'b0;
    ctrl_m = 2'b00;
    pressed = '0;
    reset = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_sel_i = 4'hF;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_fil", 32'(fil), 32'hF);
    chk("rst_ack", 32'(wb_ack_o), 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_intr", 32'(intr), 0);
    reset = 1'b1;

    // Reset in the middle of a scan with an event pending.
    wb(1'b1, 4'h8, 32'h3, r);
    press(7);
    @(negedge clk);
    chk("intr_pending", 32'(intr), 1);
    wait_fil(4'hB);
    #2 reset = 1'b0;
    #1;
    chk("midrst_fil", 32'(fil), 32'hF);
    chk("midrst_intr", 32'(intr), 0);
    chk("midrst_ack", 32'(wb_ack_o), 0);
    pressed = '0;
    exp_q.delete();
    ovf_m = 1'b0;
    ctrl_m = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd_status(r);
    chk("status_after_rst", r, 0);
    wb(1'b0, 4'h8, 0, r);
    chk("ctrl_after_rst", r, 0);

    // Single press on row 2, column 1.
    wb(1'b1, 4'h8, 32'h3, r);
    wb(1'b0, 4'h8, 0, r);
    chk("ctrl_rd", r, 32'h3);
    press(7);
    rd_status(r);
    chk("status_key7", r, 32'h11);
    rd_data(r);
    chk("key7_code", r, 32'h107);
    rd_data(r);
    chk("empty_read", r, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("intr_drop", 32'(intr), 0);
    release_k(7);
    drain();

    // Held strobe: an ack every other cycle.
    acks = 0;
    @(negedge clk);
    wb_adr_i = 32'h8;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (wb_ack_o) acks++;
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    chk("b2b_acks", 32'(acks), 2);

    // Bounce shorter than one scan.
    pressed[4] = 1'b1;
    repeat (20) @(posedge clk);
    pressed[4] = 1'b0;
    settle();
    rd_status(r);
    chk("bounce_status", r, 0);

    // Nine keys with no reads overflow the FIFO.
    for (int k = 0; k < 9; k++) begin
      press(k);
      release_k(k);
    end
    rd_status(r);
    chk("ovf_status", r, 32'h83);
    rd_data(r);
    chk("ovf_first", r, 32'h100);
    drain();
    rd_status(r);
    chk("ovf_sticky", r, 32'h02);
    wb(1'b1, 4'h0, 32'h2, r);
    rd_status(r);
    chk("ovf_clear", r, 0);

    // Two keys in one row report in column order.
    pressed[3] = 1'b1;
    pressed[5] = 1'b1;
    settle();
    model_ev(32'h103);
    model_ev(32'h105);
    rd_data(r);
    chk("pair_first", r, 32'h103);
    rd_data(r);
    chk("pair_second", r, 32'h105);
    pressed[3] = 1'b0;
    pressed[5] = 1'b0;
    settle();
    if (REL) begin
      model_ev(32'h113);
      model_ev(32'h115);
    end
    drain();

    // Press/release key 0, then disable mid-scan.
    press(0);
    release_k(0);
    wait_fil(4'hD);
    wb(1'b1, 4'h8, 32'h0, r);
    chk("disable_fil", 32'(fil), 32'hF);
    rd_status(r);
`ifdef KEYSCAN_RELEASE_EN
    chk("kept_status", r, 32'h21);
`else
    chk("kept_status", r, 32'h11);
`endif
    rd_data(r);
    chk("kept_press", r, 32'h100);
`ifdef KEYSCAN_RELEASE_EN
    rd_data(r);
    chk("kept_release", r, 32'h110);
`endif
    rd_data(r);
    chk("kept_empty", r, 0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
